// File: rtl/tick_scheduler.sv
// tick_scheduler: shared tick prescaler, free-running tick counter and NUM_CH
// one-shot/periodic countdown channels with pending flags and a masked irq.
module tick_scheduler #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int SUBSAMP = 50000,
   parameter int NUM_CH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  chipselect,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] writedata,
   output logic [DATA_WIDTH-1:0] readdata,
   output logic                  irq
);
   localparam int PW = $clog2(SUBSAMP);
   logic wr, rd, en, tick;
   logic [PW-1:0] presc;
   logic [DATA_WIDTH-1:0] ticks, rdata;
   logic [NUM_CH-1:0] pend, mask, running, periodic, expire;
   logic [DATA_WIDTH-1:0] reload [NUM_CH];
   logic [DATA_WIDTH-1:0] count [NUM_CH];

   assign wr = chipselect & write;
   assign rd = chipselect & read;
   assign tick = en && presc == PW'(SUBSAMP - 1);
   assign irq = |(pend & mask);

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         en <= 1'b0;
         presc <= '0;
         ticks <= '0;
         pend <= '0;
         mask <= '0;
         readdata <= '0;
      end else begin
         if (wr && address == ADDR_WIDTH'(0)) en <= writedata[0];
         presc <= (wr && address == ADDR_WIDTH'(0) && writedata[1]) || tick ? '0 : en ? presc + 1'b1 : presc;
         ticks <= wr && address == ADDR_WIDTH'(3) ? writedata : tick ? ticks + 1'b1 : ticks;
         // hardware set is OR-ed in after the W1C so a colliding set survives
         pend <= (wr && address == ADDR_WIDTH'(1) ? pend & ~writedata[NUM_CH-1:0] : pend) | expire;
         if (wr && address == ADDR_WIDTH'(2)) mask <= writedata[NUM_CH-1:0];
         if (rd) readdata <= rdata;
      end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [ADDR_WIDTH-1:0] A_RELOAD = ADDR_WIDTH'(4 + 3 * c);
      localparam logic [ADDR_WIDTH-1:0] A_CCTRL = ADDR_WIDTH'(5 + 3 * c);
      logic run, per, cmd;
      logic [DATA_WIDTH-1:0] rl, cnt;
      // a START/STOP write pre-empts the tick in the same cycle
      assign cmd = wr && address == A_CCTRL && (writedata[0] || writedata[1]);
      assign expire[c] = tick && run && !cmd && cnt == DATA_WIDTH'(1);
      assign running[c] = run;
      assign periodic[c] = per;
      assign reload[c] = rl;
      assign count[c] = cnt;
      always_ff @(posedge clk or negedge reset_n)
         if (!reset_n) begin
            run <= 1'b0;
            per <= 1'b0;
            rl <= '0;
            cnt <= '0;
         end else begin
            if (wr && address == A_RELOAD) rl <= writedata;
            if (wr && address == A_CCTRL) per <= writedata[2];
            if (cmd) begin
               if (writedata[1]) run <= 1'b0;
               else if (rl != '0) begin
                  run <= 1'b1;
                  cnt <= rl;
               end
            end else if (expire[c]) begin
               run <= per && rl != '0;
               cnt <= per ? rl : '0;
            end else if (tick && run) cnt <= cnt - 1'b1;
         end
   end

   always_comb begin
      rdata = '0;
      if (address == ADDR_WIDTH'(0)) rdata[0] = en;
      if (address == ADDR_WIDTH'(1)) rdata[NUM_CH-1:0] = pend;
      if (address == ADDR_WIDTH'(2)) rdata[NUM_CH-1:0] = mask;
      if (address == ADDR_WIDTH'(3)) rdata = ticks;
      for (int c = 0; c < NUM_CH; c++) begin
         if (address == ADDR_WIDTH'(4 + 3 * c)) rdata = reload[c];
         if (address == ADDR_WIDTH'(5 + 3 * c)) begin
            rdata[0] = running[c];
            rdata[2] = periodic[c];
         end
         if (address == ADDR_WIDTH'(6 + 3 * c)) rdata = count[c];
      end
   end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed and random bus traffic against a deadline-based
// reference model of the tick scheduler (expiry = absolute tick number).
module tb_tick_scheduler;
   localparam int DW = 32, AW = 4, SS = 10, NC = 4;
   logic clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, read = 1'b0, write = 1'b0;
   logic [AW-1:0] address = '0;
   logic [DW-1:0] writedata = '0;
   logic [DW-1:0] readdata;
   logic irq;
   int n_chk = 0, n_fail = 0, cyc = 0;

   tick_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SUBSAMP(SS), .NUM_CH(NC)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .read(read), .write(write), .writedata(writedata), .readdata(readdata), .irq(irq));

   always #5 clk = ~clk;

   // model: channels hold the absolute tick number at which they next expire
   logic m_en;
   int m_phase;
   longint m_gt;
   logic [DW-1:0] m_ticks, m_rdata;
   logic [NC-1:0] m_pend, m_mask, m_run, m_per;
   logic [DW-1:0] m_reload [NC];
   logic [DW-1:0] m_hold [NC];
   longint m_due [NC];

   task automatic m_reset();
      m_en = 1'b0; m_phase = 0; m_gt = 0; m_ticks = '0; m_rdata = '0;
      m_pend = '0; m_mask = '0; m_run = '0; m_per = '0;
      for (int c = 0; c < NC; c++) begin
         m_reload[c] = '0; m_hold[c] = '0; m_due[c] = 0;
      end
   endtask

   function automatic logic [DW-1:0] m_count(input int c);
      return m_run[c] ? DW'(m_due[c] - m_gt) : m_hold[c];
   endfunction

   function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
      logic [DW-1:0] r;
      int k, f;
      r = '0;
      k = (int'(a) - 4) / 3;
      f = (int'(a) - 4) % 3;
      if (a == 4'd0) r[0] = m_en;
      else if (a == 4'd1) r[NC-1:0] = m_pend;
      else if (a == 4'd2) r[NC-1:0] = m_mask;
      else if (a == 4'd3) r = m_ticks;
      else if (k < NC) begin
         if (f == 0) r = m_reload[k];
         else if (f == 1) begin
            r[0] = m_run[k];
            r[2] = m_per[k];
         end else r = m_count(k);
      end
      return r;
   endfunction

   task automatic m_step(input logic cs, re, we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic tk, w;
      logic [NC-1:0] set;
      longint g1;
      w = cs && we;
      tk = m_en && m_phase == SS - 1;
      g1 = m_gt + (tk ? 1 : 0);
      set = '0;
      if (cs && re) m_rdata = m_read(a);
      for (int c = 0; c < NC; c++) begin
         if (w && a == AW'(5 + 3 * c) && (d[0] || d[1])) begin
            if (d[1]) begin
               m_hold[c] = m_count(c);
               m_run[c] = 1'b0;
            end else if (m_reload[c] != 0) begin
               m_run[c] = 1'b1;
               m_due[c] = g1 + longint'(m_reload[c]);
            end
         end else if (tk && m_run[c] && m_due[c] == g1) begin
            set[c] = 1'b1;
            if (m_per[c] && m_reload[c] != 0) m_due[c] = g1 + longint'(m_reload[c]);
            else begin
               m_run[c] = 1'b0;
               m_hold[c] = '0;
            end
         end
         if (w && a == AW'(5 + 3 * c)) m_per[c] = d[2];
         if (w && a == AW'(4 + 3 * c)) m_reload[c] = d;
      end
      m_pend = ((w && a == 4'd1) ? m_pend & ~d[NC-1:0] : m_pend) | set;
      if (w && a == 4'd2) m_mask = d[NC-1:0];
      m_ticks = (w && a == 4'd3) ? d : m_ticks + DW'(tk);
      m_phase = ((w && a == 4'd0 && d[1]) || tk) ? 0 : m_en ? m_phase + 1 : m_phase;
      if (w && a == 4'd0) m_en = d[0];
      m_gt = g1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bus(input logic cs, re, we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      chipselect = cs; read = re; write = we; address = a; writedata = d;
      @(posedge clk);
      m_step(cs, re, we, a, d);
      cyc++;
      #1;
      check("irq", DW'(irq), DW'(|(m_pend & m_mask)));
      check("readdata", readdata, m_rdata);
   endtask

   task automatic idle(input int n);
      repeat (n) bus(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus(1'b1, 1'b0, 1'b1, a, d);
   endtask

   task automatic do_rd(input logic [AW-1:0] a);
      bus(1'b1, 1'b1, 1'b0, a, '0);
   endtask

   task automatic wait_irq(input string tag, output int t);
      int i;
      i = 0;
      while (!irq && i < 200) begin
         idle(1);
         i++;
      end
      check(tag, DW'(irq), 1);
      t = cyc;
   endtask

   // idle until the coming cycle is a tick (optionally also ch0's expiry)
   task automatic wait_tick_next(input string tag, input bit need_ch0);
      int i;
      i = 0;
      while (!(m_en && m_phase == SS - 1 && (!need_ch0 || (m_run[0] && m_due[0] == m_gt + 1))) && i < 300) begin
         idle(1);
         i++;
      end
      check(tag, DW'(i < 300), 1);
   endtask

   initial begin
      int t1, t2, t3, t4, op, ch;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_irq", DW'(irq), 0);
      check("reset_readdata", readdata, 0);
      reset_n = 1'b1;
      for (int a = 0; a < 16; a++) do_rd(AW'(a));

      do_wr(0, 1);
      idle(30);
      do_rd(3);
      check("ticks_after_30", readdata, 3);
      do_wr(0, 0);
      idle(25);
      do_rd(3);
      check("ticks_frozen", readdata, 3);

      do_wr(0, 2);
      do_wr(4, 5);
      do_wr(2, 1);
      do_wr(5, 1);
      do_wr(0, 1);
      idle(49);
      check("oneshot_irq_49", DW'(irq), 0);
      idle(1);
      check("oneshot_irq_50", DW'(irq), 1);
      do_rd(1);
      check("oneshot_pend", readdata, 1);
      do_rd(5);
      check("oneshot_idle", readdata, 0);
      do_rd(6);
      check("oneshot_count", readdata, 0);
      do_wr(1, 1);
      check("irq_w1c", DW'(irq), 0);

      do_wr(7, 3);
      do_wr(8, 5);
      do_wr(2, 2);
      wait_irq("per_rise1", t1);
      do_wr(1, 2);
      wait_irq("per_rise2", t2);
      do_wr(1, 2);
      do_wr(7, 2);
      wait_irq("per_rise3", t3);
      do_wr(1, 2);
      wait_irq("per_rise4", t4);
      check("per_gap_3a", DW'(t2 - t1), 30);
      check("per_gap_3b", DW'(t3 - t2), 30);
      check("per_gap_2", DW'(t4 - t3), 20);
      do_wr(8, 2);
      do_wr(1, 15);

      do_wr(4, 2);
      do_wr(5, 5);
      wait_tick_next("wait_expiry", 1'b1);
      do_wr(1, 1);
      do_rd(1);
      check("set_beats_w1c", DW'(readdata[0]), 1);
      do_wr(4, 7);
      wait_tick_next("wait_tick", 1'b0);
      do_wr(5, 5);
      do_rd(6);
      check("start_in_tick", readdata, 7);
      do_wr(5, 2);
      do_wr(1, 15);

      do_wr(11, 1);
      do_rd(11);
      check("start_reload0", readdata, 0);
      idle(30);
      do_rd(1);
      check("reload0_no_pend", DW'(readdata[2]), 0);

      do_wr(3, 32'hFFFF_FFFF);
      idle(SS);
      do_rd(3);
      check("ticks_wrap", readdata, 0);

      do_wr(0, 2);
      do_wr(1, 15);
      for (int c = 0; c < NC; c++) do_wr(AW'(4 + 3 * c), DW'(c + 1));
      do_wr(2, 5);
      for (int c = 0; c < NC; c++) do_wr(AW'(5 + 3 * c), 5);
      do_wr(0, 1);
      idle(10);
      do_rd(1);
      check("multi_pend_t10", readdata, 1);
      idle(9);
      do_rd(1);
      check("multi_pend_t20", readdata, 3);
      idle(40);
      check("irq_before_reset", DW'(irq), 1);

      #3;
      reset_n = 1'b0;
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
      #1;
      check("async_reset_irq", DW'(irq), 0);
      check("async_reset_readdata", readdata, 0);
      m_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int a = 0; a < 16; a++) do_rd(AW'(a));

      do_wr(0, 1);
      for (int i = 0; i < 3000; i++) begin
         op = $urandom_range(0, 9);
         ch = $urandom_range(0, NC - 1);
         if (op < 4) idle(1);
         else if (op == 4) do_rd(AW'($urandom_range(0, 15)));
         else if (op == 5) do_wr(AW'(4 + 3 * ch), DW'($urandom_range(0, 6)));
         else if (op == 6) do_wr(AW'(5 + 3 * ch), DW'($urandom_range(0, 7)));
         else if (op == 7) do_wr(AW'($urandom_range(1, 2)), DW'($urandom_range(0, 15)));
         else if (op == 8) do_wr(0, ($urandom_range(0, 7) == 0) ? DW'($urandom_range(0, 3)) : 1);
         else bus(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
